fiber_access_blk16: RTL and testbench

// - Block-mode fiber buffer for one sparse tensor level, between two GLB streams.
// - Write side accepts blocks of 16-bit words from the GLB and stores them in an external

---
 rtl/fiber_access_blk16_if.sv | 21 ++
 rtl/fiber_access_blk16.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_fiber_access_blk16.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fiber_access_blk16_if.sv
// Write and read GLB token streams of the block-mode fiber buffer.
interface fiber_access_blk16_if #(
  parameter int DW = 16
);
  logic [DW:0] block_wr_in;
  logic        block_wr_in_valid;
  logic        block_wr_in_ready;
  logic [DW:0] block_rd_out;
  logic        block_rd_out_valid;
  logic        block_rd_out_ready;

  modport master (
    output block_wr_in, block_wr_in_valid, block_rd_out_ready,
    input  block_wr_in_ready, block_rd_out, block_rd_out_valid
  );

  modport slave (
    input  block_wr_in, block_wr_in_valid, block_rd_out_ready,
    output block_wr_in_ready, block_rd_out, block_rd_out_valid
  );
endinterface

// File: rtl/fiber_access_blk16.sv
// Double-buffered block fiber buffer: packs incoming blocks into a shared
// single-port SRAM (4 words per line) and streams committed blocks back out
// in arrival order through a 2-entry output FIFO.
module fiber_access_blk16 #(
  parameter int MEM_DEPTH = 512,
  parameter int DW        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic                         flush,
  input  logic                         tile_en,
  input  logic [7:0]                   buffet_capacity_log,
  fiber_access_blk16_if.slave          io,
  output logic [$clog2(MEM_DEPTH)-1:0] addr_to_mem,
  output logic [4*DW-1:0]              data_to_mem,
  output logic                         wen_to_mem,
  output logic                         ren_to_mem,
  input  logic [4*DW-1:0]              data_from_mem
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int LW = 4 * DW;
  localparam logic [DW:0] DONE_TOK = (DW+1)'(17'h10100);

  typedef enum logic [2:0] {W_IDLE, W_HDR, W_DATA, W_COMMIT, W_DONE} wstate_t;
  typedef enum logic [2:0] {R_IDLE, R_HDR, R_DATA, R_EMIT_DONE, R_END} rstate_t;

  function automatic logic [DW:0] cap_words(input logic [3:0] c);
    return (DW+1)'(1) << c;
  endfunction

  wstate_t       wstate;
  rstate_t       rstate;
  logic          active;
  logic [1:0]    full;
  logic          wp, rp;
  logic [DW-1:0] plen [2];
  logic          done_pending;

  // write side
  logic [DW-1:0] wl, wleff, wcnt;
  logic [LW-1:0] wline, line_next;
  logic          wpend;
  logic [LW-1:0] wdata;
  logic [AW-1:0] waddr;
  logic [DW:0]   wcap;
  logic [DW-1:0] hdr_len, hdr_eff;
  logic          ready_int, wr_acc, commit;

  // read side
  logic [DW-1:0] rlen, nlines, lines_issued, words_cap, words_pushed, rem;
  logic [2:0]    cnt_new;
  logic          cap_pend, lb_valid;
  logic [LW-1:0] lb_data;
  logic [1:0]    lb_lane;
  logic [2:0]    lb_cnt;
  logic          rd_wants, rd_issue, rd_clear;
  logic [AW-1:0] base1, raddr;
  logic          wen_q, ren_q;

  // output FIFO
  logic [DW:0]   fmem [2];
  logic          fwr, frd;
  logic [1:0]    fcnt;
  logic          push, pop, fifo_room;
  logic [DW:0]   push_tok;
  logic [DW-1:0] lane_word;

  assign active  = clk_en & tile_en;
  assign base1   = AW'(cap_words(buffet_capacity_log[3:0]) >> 2);
  assign wcap    = cap_words(wp ? buffet_capacity_log[7:4] : buffet_capacity_log[3:0]);
  assign hdr_len = io.block_wr_in[DW-1:0];
  assign hdr_eff = ({1'b0, hdr_len} > wcap) ? wcap[DW-1:0] : hdr_len;
  assign nlines  = DW'(({1'b0, rlen} + (DW+1)'(3)) >> 2);
  assign rem     = rlen - words_cap;
  assign cnt_new = (rem > DW'(4)) ? 3'd4 : rem[2:0];
  assign raddr   = (rp ? base1 : '0) + lines_issued[AW-1:0];

  assign rd_wants = (rstate == R_DATA) && (lines_issued < nlines) &&
                    !ren_q && !cap_pend && !lb_valid;
  assign rd_issue = active && rd_wants && !wpend;
  assign commit   = active && (wstate == W_COMMIT);

  assign pop       = active && (fcnt != 2'd0) && io.block_rd_out_ready;
  assign fifo_room = (fcnt != 2'd2) || pop;

  assign io.block_wr_in_ready  = ready_int & tile_en;
  assign io.block_rd_out_valid = tile_en & (fcnt != 2'd0);
  assign io.block_rd_out       = fmem[frd];
  assign wen_to_mem            = wen_q & tile_en;
  assign ren_to_mem            = ren_q & tile_en;
  assign wr_acc                = io.block_wr_in_valid & ready_int & active;

  // Write-side ready: header waits for an empty partition; payload yields
  // for one cycle when a line write would otherwise starve a pending read.
  always_comb begin
    ready_int = 1'b0;
    case (wstate)
      W_HDR:   ready_int = !full[wp];
      W_DATA:  ready_int = !(wpend && rd_wants);
      default: ready_int = 1'b0;
    endcase
  end

  // Merge the incoming word into the packing line; lane 0 starts a fresh line.
  always_comb begin
    line_next = (wcnt[1:0] == 2'd0) ? '0 : wline;
    line_next[wcnt[1:0]*DW +: DW] = io.block_wr_in[DW-1:0];
  end

  // Select the single token entering the output FIFO this cycle.
  always_comb begin
    push      = 1'b0;
    push_tok  = '0;
    lane_word = lb_data[lb_lane*DW +: DW];
    if (active) begin
      case (rstate)
        R_HDR:       if (full[rp] && fifo_room) begin
                       push = 1'b1; push_tok = {1'b0, plen[rp]};
                     end
        R_DATA:      if (lb_valid && fifo_room) begin
                       push = 1'b1; push_tok = {1'b0, lane_word};
                     end
        R_EMIT_DONE: if (fifo_room) begin
                       push = 1'b1; push_tok = DONE_TOK;
                     end
        default:     ;
      endcase
    end
  end

  assign rd_clear = active &&
                    (((rstate == R_HDR) && push && (plen[rp] == '0)) ||
                     ((rstate == R_DATA) && (words_pushed == rlen) &&
                      (fcnt == 2'd0) && !lb_valid));

  // Write FSM: header latch, line packing, commit and done tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate <= W_IDLE; wp <= 1'b0; wl <= '0; wleff <= '0; wcnt <= '0;
      wline <= '0; wpend <= 1'b0; wdata <= '0; waddr <= '0;
      done_pending <= 1'b0; plen[0] <= '0; plen[1] <= '0;
    end else if (flush) begin
      wstate <= W_IDLE; wp <= 1'b0; wl <= '0; wleff <= '0; wcnt <= '0;
      wline <= '0; wpend <= 1'b0; wdata <= '0; waddr <= '0;
      done_pending <= 1'b0; plen[0] <= '0; plen[1] <= '0;
    end else if (active) begin
      wpend <= 1'b0;
      case (wstate)
        W_IDLE: wstate <= W_HDR;
        W_HDR: if (wr_acc) begin
          if (io.block_wr_in[DW]) begin
            done_pending <= 1'b1;
            wstate       <= W_DONE;
          end else begin
            wl     <= hdr_len;
            wleff  <= hdr_eff;
            wcnt   <= '0;
            wstate <= (hdr_len == '0) ? W_COMMIT : W_DATA;
          end
        end
        W_DATA: if (wr_acc) begin
          // Words beyond the truncated length are accepted but not stored.
          if (wcnt < wleff) begin
            wline <= line_next;
            if ((wcnt[1:0] == 2'd3) || (wcnt == wleff - DW'(1))) begin
              wpend <= 1'b1;
              wdata <= line_next;
              waddr <= (wp ? base1 : '0) + wcnt[AW+1:2];
            end
          end
          wcnt <= wcnt + DW'(1);
          if (wcnt == wl - DW'(1)) wstate <= W_COMMIT;
        end
        W_COMMIT: begin
          plen[wp] <= wleff;
          wp       <= ~wp;
          wstate   <= W_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Partition occupancy: commit fills the write partition, read drain empties the read one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else if (flush) begin
      full <= '0;
    end else begin
      if (commit)   full[wp] <= 1'b1;
      if (rd_clear) full[rp] <= 1'b0;
    end
  end

  // SRAM port: a pending line write always wins; reads retry next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q <= 1'b0; ren_q <= 1'b0; addr_to_mem <= '0; data_to_mem <= '0;
    end else if (flush) begin
      wen_q <= 1'b0; ren_q <= 1'b0; addr_to_mem <= '0; data_to_mem <= '0;
    end else if (active) begin
      if (wpend) begin
        wen_q <= 1'b1; ren_q <= 1'b0; addr_to_mem <= waddr; data_to_mem <= wdata;
      end else if (rd_issue) begin
        wen_q <= 1'b0; ren_q <= 1'b1; addr_to_mem <= raddr;
      end else begin
        wen_q <= 1'b0; ren_q <= 1'b0;
      end
    end
  end

  // Read FSM: header emit, line fetch into a one-line buffer, lane extraction, done emit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate <= R_IDLE; rp <= 1'b0; rlen <= '0; lines_issued <= '0;
      words_cap <= '0; words_pushed <= '0; cap_pend <= 1'b0;
      lb_valid <= 1'b0; lb_data <= '0; lb_lane <= '0; lb_cnt <= '0;
    end else if (flush) begin
      rstate <= R_IDLE; rp <= 1'b0; rlen <= '0; lines_issued <= '0;
      words_cap <= '0; words_pushed <= '0; cap_pend <= 1'b0;
      lb_valid <= 1'b0; lb_data <= '0; lb_lane <= '0; lb_cnt <= '0;
    end else if (active) begin
      // Only one line is ever in flight and the buffer must be empty to
      // issue it, so returning data always has somewhere to land.
      cap_pend <= ren_q;
      case (rstate)
        R_IDLE: rstate <= R_HDR;
        R_HDR: begin
          if (push) begin
            rlen         <= plen[rp];
            lines_issued <= '0;
            words_cap    <= '0;
            words_pushed <= '0;
            if (plen[rp] == '0) rp <= ~rp;
            else                rstate <= R_DATA;
          end else if ((full == 2'b00) && done_pending) begin
            rstate <= R_EMIT_DONE;
          end
        end
        R_DATA: begin
          if (rd_issue) lines_issued <= lines_issued + DW'(1);
          if (cap_pend) begin
            lb_valid  <= 1'b1;
            lb_data   <= data_from_mem;
            lb_lane   <= '0;
            lb_cnt    <= cnt_new;
            words_cap <= words_cap + DW'(cnt_new);
          end else if (push) begin
            lb_lane      <= lb_lane + 2'd1;
            lb_cnt       <= lb_cnt - 3'd1;
            words_pushed <= words_pushed + DW'(1);
            if (lb_cnt == 3'd1) lb_valid <= 1'b0;
          end
          if (rd_clear) begin
            rp     <= ~rp;
            rstate <= R_HDR;
          end
        end
        R_EMIT_DONE: if (push) rstate <= R_END;
        default: ;
      endcase
    end
  end

  // Two-entry output FIFO holding tokens for the read stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) fmem[i] <= '0;
      fwr <= 1'b0; frd <= 1'b0; fcnt <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < 2; i++) fmem[i] <= '0;
      fwr <= 1'b0; frd <= 1'b0; fcnt <= '0;
    end else begin
      if (push) begin
        fmem[fwr] <= push_tok;
        fwr       <= ~fwr;
      end
      if (pop) frd <= ~frd;
      case ({push, pop})
        2'b10:   fcnt <= fcnt + 2'd1;
        2'b01:   fcnt <= fcnt - 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fiber_access_blk16.sv
// Randomized bench for fiber_access_blk16: a token-level reference model
// (queue of expected output tokens) plus a behavioural SRAM.
module tb_fiber_access_blk16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        flush = 1'b0;
  logic        tile_en = 1'b1;
  logic [7:0]  cap_log = 8'h88;
  logic [8:0]  addr;
  logic [63:0] wdata;
  logic [63:0] rdata = '0;
  logic        wen, ren;

  fiber_access_blk16_if #(.DW(16)) io ();

  fiber_access_blk16 #(.MEM_DEPTH(512), .DW(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .clk_en              (clk_en),
    .flush               (flush),
    .tile_en             (tile_en),
    .buffet_capacity_log (cap_log),
    .io                  (io),
    .addr_to_mem         (addr),
    .data_to_mem         (wdata),
    .wen_to_mem          (wen),
    .ren_to_mem          (ren),
    .data_from_mem       (rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM with one-cycle read latency plus port activity logs.
  logic [63:0] mem [512];
  int          wen_cnt = 0;
  int          ren_cnt = 0;
  int          both_err = 0;
  logic [8:0]  wen_addr_log [64];
  logic [63:0] wen_data_log [64];

  always @(posedge clk) begin
    if (wen) begin
      mem[addr] <= wdata;
      if (wen_cnt < 64) begin
        wen_addr_log[wen_cnt] <= addr;
        wen_data_log[wen_cnt] <= wdata;
      end
      wen_cnt <= wen_cnt + 1;
    end
    if (ren) begin
      rdata   <= mem[addr];
      ren_cnt <= ren_cnt + 1;
    end
    if (wen && ren) both_err <= both_err + 1;
  end

  int          checks = 0;
  int          failures = 0;
  logic [16:0] wr_q [$];
  logic [16:0] exp_q [$];
  int          acc_count = 0;
  int          rd_mode = 0;
  int          blk_idx = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: header carries min(L, 2^cap of the target partition);
  // only that many leading payload words come back. Blocks alternate partitions.
  task automatic add_block(input int len);
    int cap, eff;
    logic [15:0] w;
    cap = (blk_idx % 2 == 0) ? int'(cap_log[3:0]) : int'(cap_log[7:4]);
    eff = (len > (1 << cap)) ? (1 << cap) : len;
    blk_idx++;
    wr_q.push_back({1'b0, 16'(len)});
    exp_q.push_back({1'b0, 16'(eff)});
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      wr_q.push_back({1'b0, w});
      if (i < eff) exp_q.push_back({1'b0, w});
    end
  endtask

  task automatic add_done();
    wr_q.push_back(17'h10100);
    exp_q.push_back(17'h10100);
  endtask

  task automatic drive_wr(input int max_gap);
    logic [16:0] tok;
    int waitc;
    while (wr_q.size() > 0) begin
      tok = wr_q.pop_front();
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      io.block_wr_in       = tok;
      io.block_wr_in_valid = 1'b1;
      waitc = 0;
      while (!io.block_wr_in_ready && waitc < 3000) begin
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 3000) begin
        check_eq("wr_timeout", 64'(io.block_wr_in_ready), 64'd1);
        wr_q.delete();
        io.block_wr_in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      acc_count++;
      io.block_wr_in_valid = 1'b0;
    end
  endtask

  task automatic mon_rd(input int budget);
    int cyc;
    int extra;
    logic r, held;
    logic [16:0] held_tok;
    cyc = 0; held = 1'b0; held_tok = '0; r = 1'b1;
    while (exp_q.size() > 0 && cyc < budget) begin
      case (rd_mode)
        1:       r = (cyc % 2 == 0);
        2:       r = ($urandom_range(3, 0) != 0);
        3:       r = 1'b0;
        default: r = 1'b1;
      endcase
      io.block_rd_out_ready = r;
      if (held) begin
        check_eq("valid_hold", 64'(io.block_rd_out_valid), 64'd1);
        check_eq("data_hold", 64'(io.block_rd_out), 64'(held_tok));
      end
      if (io.block_rd_out_valid && r) begin
        check_eq("rd_tok", 64'(io.block_rd_out), 64'(exp_q.pop_front()));
        held = 1'b0;
      end else begin
        held     = io.block_rd_out_valid;
        held_tok = io.block_rd_out;
      end
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > 0) check_eq("rd_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    io.block_rd_out_ready = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (io.block_rd_out_valid) extra++;
    end
    check_eq("no_extra", 64'(extra), 64'd0);
  endtask

  task automatic run_sc(input int max_gap);
    fork
      drive_wr(max_gap);
      mon_rd(5000);
    join
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    blk_idx = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int b;
    io.block_wr_in        = '0;
    io.block_wr_in_valid  = 1'b0;
    io.block_rd_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_rd_valid", 64'(io.block_rd_out_valid), 64'd0);
    check_eq("rst_rd_out", 64'(io.block_rd_out), 64'd0);
    check_eq("rst_wr_ready", 64'(io.block_wr_in_ready), 64'd0);
    check_eq("rst_mem_ctl", {61'd0, wen, ren, 1'b0}, 64'd0);
    check_eq("rst_mem_bus", 64'(addr) | wdata, 64'd0);
    rst_n = 1'b1;

    // Short block with known payload and a single packed line.
    b = wen_cnt;
    wr_q = '{17'h00003, 17'h0000A, 17'h0000B, 17'h0000C, 17'h10100};
    exp_q = wr_q;
    rd_mode = 0;
    run_sc(0);
    check_eq("s1_wen_count", 64'(wen_cnt - b), 64'd1);
    check_eq("s1_wen_addr", 64'(wen_addr_log[b]), 64'd0);
    check_eq("s1_wen_data", wen_data_log[b], 64'h0000_000C_000B_000A);
    do_flush();
    check_eq("flush_rd_valid", 64'(io.block_rd_out_valid), 64'd0);

    // Two blocks; second lands in partition 1 at line 64.
    b = wen_cnt;
    add_block(5); add_block(2); add_done();
    run_sc(0);
    check_eq("s2_wen_count", 64'(wen_cnt - b), 64'd3);
    check_eq("s2_addr0", 64'(wen_addr_log[b]), 64'd0);
    check_eq("s2_addr1", 64'(wen_addr_log[b+1]), 64'd1);
    check_eq("s2_addr2", 64'(wen_addr_log[b+2]), 64'd64);
    do_flush();

    // Toggling read backpressure on an 8-word block.
    add_block(8); add_done();
    rd_mode = 1;
    run_sc(0);
    do_flush();

    // Both partitions full stalls the third block until reads resume.
    acc_count = 0;
    add_block(4); add_block(4); add_block(4); add_done();
    rd_mode = 3;
    fork
      drive_wr(0);
      mon_rd(5000);
      begin
        repeat (80) @(negedge clk);
        check_eq("s4_accepted", 64'(acc_count), 64'd10);
        check_eq("s4_wr_ready", 64'(io.block_wr_in_ready), 64'd0);
        rd_mode = 0;
      end
    join
    do_flush();

    // Empty block: header only, no SRAM traffic.
    b = wen_cnt;
    begin
      int rb;
      rb = ren_cnt;
      add_block(0); add_done();
      run_sc(0);
      check_eq("s5_no_wen", 64'(wen_cnt - b), 64'd0);
      check_eq("s5_no_ren", 64'(ren_cnt - rb), 64'd0);
    end
    do_flush();

    // Async reset mid-block discards it; a fresh block follows cleanly.
    io.block_rd_out_ready = 1'b0;
    wr_q = '{17'h00006, 17'h01111, 17'h02222};
    drive_wr(0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_valid", 64'(io.block_rd_out_valid), 64'd0);
    check_eq("s6_rst_ready", 64'(io.block_wr_in_ready), 64'd0);
    check_eq("s6_rst_memctl", {62'd0, wen, ren}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    blk_idx = 0;
    add_block(2); add_done();
    rd_mode = 0;
    run_sc(0);
    do_flush();

    // Randomized capacities, lengths (including truncation), gaps and backpressure.
    for (int s = 0; s < 4; s++) begin
      cap_log = {4'($urandom_range(5, 2)), 4'($urandom_range(5, 2))};
      do_flush();
      for (int k = 0; k < int'($urandom_range(6, 3)); k++) add_block(int'($urandom_range(12, 0)));
      add_done();
      rd_mode = 2;
      run_sc(2);
    end

    check_eq("wen_ren_excl", 64'(both_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
